trap_ctrl: RTL and testbench

Trap controller sitting directly upstream of the CSR file. Each cycle it examines the instruction at the commit point together with pending interrupts, and selects at most one trap by fixed priority. For that trap it drives the one-cycle context-switch pulse, the cause word and the saved PC into the CSR file. It then sequences the pipeline flush and the redirect to the trap vector that the CSR file produces.

---
 rtl/trap_pkg.sv | 30 +++
 rtl/trap_ctrl_if.sv | 38 +++
 rtl/trap_prio_enc.sv | 33 +++
 rtl/trap_ctrl.sv | 112 +++++++++++
 tb/tb_trap_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/trap_pkg.sv
// Shared trap-controller definitions: cause codes, FSM encoding and the
// priority-encoder result payload.
package trap_pkg;

   localparam int unsigned CODE_W = 6;

   localparam logic [CODE_W-1:0] CAUSE_MISALIGN   = 6'd0;
   localparam logic [CODE_W-1:0] CAUSE_ILLEGAL    = 6'd2;
   localparam logic [CODE_W-1:0] CAUSE_EBREAK     = 6'd3;
   localparam logic [CODE_W-1:0] CAUSE_ECALL_BASE = 6'd8;
   localparam logic [CODE_W-1:0] CAUSE_MEI        = 6'd11;
   localparam logic [CODE_W-1:0] CAUSE_MSI        = 6'd3;
   localparam logic [CODE_W-1:0] CAUSE_MTI        = 6'd7;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] TRAP     = 2'd1;
   localparam logic [1:0] REDIRECT = 2'd2;

   typedef struct packed {
      logic              take;
      logic              is_irq;
      logic [CODE_W-1:0] code;
   } trap_sel_t;

   // ECALL cause depends on the privilege level the call came from
   function automatic logic [CODE_W-1:0] ecall_code(input logic [1:0] priv);
      return CAUSE_ECALL_BASE + CODE_W'(priv);
   endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Commit-point, interrupt and CSR-file signals of the trap controller.
interface trap_ctrl_if #(
   parameter int unsigned XLEN = 64
);

   logic            COMMIT_VALID;
   logic [XLEN-1:0] COMMIT_PC;
   logic            EXC_MISALIGN;
   logic            EXC_ILLEGAL;
   logic            EXC_EBREAK;
   logic            EXC_ECALL;
   logic [1:0]      PRIV;
   logic            GLOBAL_IE;
   logic            IRQ_EXT;
   logic            IRQ_SW;
   logic            IRQ_TIMER;
   logic [2:0]      IRQ_EN;
   logic            KILL;
   logic            CS;
   logic [XLEN-1:0] CAUSE;
   logic [XLEN-1:0] NPC;
   logic            FLUSH;
   logic            REDIRECT;
   logic            BUSY;

   modport master (
      output COMMIT_VALID, COMMIT_PC, EXC_MISALIGN, EXC_ILLEGAL, EXC_EBREAK,
             EXC_ECALL, PRIV, GLOBAL_IE, IRQ_EXT, IRQ_SW, IRQ_TIMER, IRQ_EN,
      input  KILL, CS, CAUSE, NPC, FLUSH, REDIRECT, BUSY
   );

   modport slave (
      input  COMMIT_VALID, COMMIT_PC, EXC_MISALIGN, EXC_ILLEGAL, EXC_EBREAK,
             EXC_ECALL, PRIV, GLOBAL_IE, IRQ_EXT, IRQ_SW, IRQ_TIMER, IRQ_EN,
      output KILL, CS, CAUSE, NPC, FLUSH, REDIRECT, BUSY
   );

endinterface

// File: rtl/trap_prio_enc.sv
// Fixed-priority trap selection: exceptions first, then eligible interrupts.
module trap_prio_enc
   import trap_pkg::*;
(
   input  logic       misalign,
   input  logic       illegal,
   input  logic       ebreak,
   input  logic       ecall,
   input  logic [2:0] irq,        // eligible interrupts {ext, timer, sw}
   input  logic [1:0] priv,
   output trap_sel_t  sel_c
);

   always_comb begin
      sel_c = '0;
      if (misalign) begin
         sel_c = '{take: 1'b1, is_irq: 1'b0, code: CAUSE_MISALIGN};
      end else if (illegal) begin
         sel_c = '{take: 1'b1, is_irq: 1'b0, code: CAUSE_ILLEGAL};
      end else if (ebreak) begin
         sel_c = '{take: 1'b1, is_irq: 1'b0, code: CAUSE_EBREAK};
      end else if (ecall) begin
         sel_c = '{take: 1'b1, is_irq: 1'b0, code: ecall_code(priv)};
      end else if (irq[2]) begin
         sel_c = '{take: 1'b1, is_irq: 1'b1, code: CAUSE_MEI};
      end else if (irq[0]) begin
         sel_c = '{take: 1'b1, is_irq: 1'b1, code: CAUSE_MSI};
      end else if (irq[1]) begin
         sel_c = '{take: 1'b1, is_irq: 1'b1, code: CAUSE_MTI};
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: selects one trap per commit, pulses CS into the CSR file,
// then sequences flush and redirect. Define TRAP_CTRL_EDGE_IRQ_EN to make the
// external interrupt edge-captured instead of level-sensitive.
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input logic        CLK,
   input logic        RESET,
   trap_ctrl_if.slave bus
);

   localparam int unsigned PAD_W = XLEN - 1 - CODE_W;

   logic [1:0]      state;
   logic [1:0]      state_d;
   trap_sel_t       sel_c;
   logic [2:0]      irq_elig;
   logic            ext_src;
   logic            take;
   logic            enter_trap;
   logic            cs_q;
   logic            flush_q;
   logic            redirect_q;
   logic            busy_q;
   logic [XLEN-1:0] cause_q;
   logic [XLEN-1:0] npc_q;

`ifdef TRAP_CTRL_EDGE_IRQ_EN
   logic ext_prev;
   logic ext_pend;
   logic ext_clr;

   // A new rising edge wins over the clear from the trap it would otherwise miss
   assign ext_clr = enter_trap & sel_c.is_irq & (sel_c.code == CAUSE_MEI);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         ext_prev <= 1'b0;
         ext_pend <= 1'b0;
      end else begin
         ext_prev <= bus.IRQ_EXT;
         ext_pend <= (ext_pend & ~ext_clr) | (bus.IRQ_EXT & ~ext_prev);
      end
   end

   assign ext_src = ext_pend;
`else
   assign ext_src = bus.IRQ_EXT;
`endif

   assign irq_elig = {ext_src & bus.IRQ_EN[2],
                      bus.IRQ_TIMER & bus.IRQ_EN[1],
                      bus.IRQ_SW & bus.IRQ_EN[0]} & {3{bus.GLOBAL_IE}};

   trap_prio_enc u_prio (
      .misalign (bus.EXC_MISALIGN & bus.COMMIT_VALID),
      .illegal  (bus.EXC_ILLEGAL  & bus.COMMIT_VALID),
      .ebreak   (bus.EXC_EBREAK   & bus.COMMIT_VALID),
      .ecall    (bus.EXC_ECALL    & bus.COMMIT_VALID),
      .irq      (irq_elig),
      .priv     (bus.PRIV),
      .sel_c    (sel_c)
   );

   assign take       = bus.COMMIT_VALID & sel_c.take;
   assign enter_trap = take & (state == IDLE) & ~RESET;

   // Next-state logic
   always_comb begin
      state_d = state;
      case (state)
         IDLE:     if (take) state_d = TRAP;
         TRAP:     state_d = REDIRECT;
         REDIRECT: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // State and registered outputs, decoded from the state being entered
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         cs_q       <= 1'b0;
         flush_q    <= 1'b0;
         redirect_q <= 1'b0;
         busy_q     <= 1'b0;
         cause_q    <= '0;
         npc_q      <= '0;
      end else begin
         state      <= state_d;
         cs_q       <= (state_d == TRAP);
         flush_q    <= (state_d == TRAP) | (state_d == REDIRECT);
         redirect_q <= (state_d == REDIRECT);
         busy_q     <= (state_d != IDLE);
         if (enter_trap) begin
            cause_q <= {sel_c.is_irq, PAD_W'(0), sel_c.code};
            npc_q   <= bus.COMMIT_PC;
         end
      end
   end

   assign bus.KILL     = enter_trap;
   assign bus.CS       = cs_q;
   assign bus.FLUSH    = flush_q;
   assign bus.REDIRECT = redirect_q;
   assign bus.BUSY     = busy_q;
   assign bus.CAUSE    = cause_q;
   assign bus.NPC      = npc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: directed test-plan cases plus random traffic
// checked against a priority-list reference model.
module tb_trap_ctrl;

   localparam int unsigned XLEN = 64;
   localparam logic [63:0] IRQ_BIT = 64'h8000_0000_0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   trap_ctrl_if #(.XLEN(XLEN)) bus ();
   trap_ctrl #(.XLEN(XLEN)) dut (.CLK(clk), .RESET(rst), .bus(bus));

   int checks   = 0;
   int failures = 0;

   logic [127:0] sb_q[$];
   int   ph        = 0;      // 0 idle, 1 trap cycle, 2 redirect cycle
   logic m_pend    = 1'b0;
   logic m_prev    = 1'b0;
   logic after_rst = 1'b0;
   logic armed     = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Reference: walk the priority list, return {take, cause}
   function automatic logic [64:0] pick(input logic cv, input logic [3:0] exc,
                                        input logic [1:0] priv, input logic gie,
                                        input logic [2:0] irq, input logic [2:0] en,
                                        input logic ext_line);
      if (!cv)                      return {1'b0, 64'd0};
      if (exc[3])                   return {1'b1, 64'd0};
      if (exc[2])                   return {1'b1, 64'd2};
      if (exc[1])                   return {1'b1, 64'd3};
      if (exc[0])                   return {1'b1, 64'd8 + 64'(priv)};
      if (gie && ext_line && en[2]) return {1'b1, IRQ_BIT | 64'd11};
      if (gie && irq[0] && en[0])   return {1'b1, IRQ_BIT | 64'd3};
      if (gie && irq[1] && en[1])   return {1'b1, IRQ_BIT | 64'd7};
      return {1'b0, 64'd0};
   endfunction

   // exc = {misalign, illegal, ebreak, ecall}; irq and en = {ext, timer, sw}
   task automatic step(input logic r, input logic cv, input logic [63:0] pc,
                       input logic [3:0] exc, input logic [1:0] priv, input logic gie,
                       input logic [2:0] irq, input logic [2:0] en);
      logic [64:0] p;
      logic        ext_line;
      logic        taken;
      @(negedge clk);
      rst              = r;
      bus.COMMIT_VALID = cv;
      bus.COMMIT_PC    = pc;
      bus.EXC_MISALIGN = exc[3];
      bus.EXC_ILLEGAL  = exc[2];
      bus.EXC_EBREAK   = exc[1];
      bus.EXC_ECALL    = exc[0];
      bus.PRIV         = priv;
      bus.GLOBAL_IE    = gie;
      bus.IRQ_EXT      = irq[2];
      bus.IRQ_TIMER    = irq[1];
      bus.IRQ_SW       = irq[0];
      bus.IRQ_EN       = en;
      #1;
      if (armed) begin
         check("busy",     64'(bus.BUSY),     64'(ph != 0));
         check("flush",    64'(bus.FLUSH),    64'(ph != 0));
         check("redirect", 64'(bus.REDIRECT), 64'(ph == 2));
         check("cs_level", 64'(bus.CS),       64'(ph == 1));
      end
      if (after_rst && ph == 0) begin
         check("rst_cause", bus.CAUSE, 64'd0);
         check("rst_npc",   bus.NPC,   64'd0);
      end
`ifdef TRAP_CTRL_EDGE_IRQ_EN
      ext_line = m_pend;
`else
      ext_line = irq[2];
`endif
      p     = pick(cv, exc, priv, gie, irq, en, ext_line);
      taken = p[64] && (ph == 0) && !r;
      check("kill", 64'(bus.KILL), 64'(taken));
      if (taken) sb_q.push_back({p[63:0], pc});
      @(posedge clk);
      if (r)            ph = 0;
      else if (ph == 0) ph = taken ? 1 : 0;
      else if (ph == 1) ph = 2;
      else              ph = 0;
      if (r) begin
         m_pend = 1'b0;
         m_prev = 1'b0;
      end else begin
         m_pend = (m_pend & ~(taken && p[63:0] == (IRQ_BIT | 64'd11))) | (irq[2] & ~m_prev);
         m_prev = irq[2];
      end
      if (r) begin
         armed     = 1'b1;
         after_rst = 1'b1;
      end else if (taken) begin
         after_rst = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'd0, 4'd0, 2'd0, 1'b0, 3'd0, 3'd0);
   endtask

   // Called right after a trap-taking step: looks at the TRAP cycle outputs
   task automatic expect_trap(input string name, input logic [63:0] cause, input logic [63:0] npc);
      #1;
      check({name, "_cause"}, bus.CAUSE, cause);
      check({name, "_npc"},   bus.NPC,   npc);
   endtask

   // Monitor: every CS pulse must match the oldest expected trap
   always @(posedge clk) begin
      logic [127:0] e;
      #1;
      if (bus.CS === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("cs_unexpected", 64'(bus.CS), 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("sb_cause", bus.CAUSE, e[127:64]);
            check("sb_npc",   bus.NPC,   e[63:0]);
         end
      end
   end

   initial begin
      step(1'b1, 1'b0, 64'd0, 4'd0, 2'd0, 1'b0, 3'd0, 3'd0);
      step(1'b1, 1'b0, 64'd0, 4'd0, 2'd0, 1'b0, 3'd0, 3'd0);
      idle(1);

      step(1'b0, 1'b1, 64'h1000, 4'b0100, 2'd0, 1'b0, 3'd0, 3'd0);
      expect_trap("illegal", 64'h2, 64'h1000);
      idle(2);

      step(1'b0, 1'b1, 64'h1100, 4'b0001, 2'd0, 1'b0, 3'd0, 3'd0);
      expect_trap("ecall_u", 64'h8, 64'h1100);
      idle(2);
      step(1'b0, 1'b1, 64'h1200, 4'b0001, 2'd3, 1'b0, 3'd0, 3'd0);
      expect_trap("ecall_m", 64'hB, 64'h1200);
      idle(2);

      for (int k = 0; k < 2; k++) begin
         step(1'b0, 1'b1, 64'h2000, 4'd0, 2'd0, 1'b1, 3'b111, 3'b111);
`ifndef TRAP_CTRL_EDGE_IRQ_EN
         expect_trap("irq_all", IRQ_BIT | 64'd11, 64'h2000);
`endif
         step(1'b0, 1'b1, 64'h2000, 4'd0, 2'd0, 1'b1, 3'b111, 3'b111);
         step(1'b0, 1'b1, 64'h2000, 4'd0, 2'd0, 1'b1, 3'b111, 3'b111);
      end
      idle(3);

      step(1'b0, 1'b1, 64'h3000, 4'b1000, 2'd0, 1'b1, 3'b010, 3'b111);
      expect_trap("exc_over_irq", 64'h0, 64'h3000);
      step(1'b0, 1'b1, 64'h3004, 4'd0, 2'd0, 1'b1, 3'b010, 3'b111);
      step(1'b0, 1'b1, 64'h3004, 4'd0, 2'd0, 1'b1, 3'b010, 3'b111);
      step(1'b0, 1'b1, 64'h3004, 4'd0, 2'd0, 1'b1, 3'b010, 3'b111);
      expect_trap("timer_pending", IRQ_BIT | 64'd7, 64'h3004);
      idle(2);

      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 64'h3100, 4'd0, 2'd0, 1'b0, 3'b010, 3'b111);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 64'h3200, 4'b0100, 2'd0, 1'b1, 3'd0, 3'd0);

      step(1'b0, 1'b1, 64'h3300, 4'b0010, 2'd0, 1'b0, 3'd0, 3'd0);
      expect_trap("ebreak", 64'h3, 64'h3300);
      step(1'b1, 1'b1, 64'h3300, 4'b0010, 2'd0, 1'b0, 3'd0, 3'd0);
      idle(3);

`ifdef TRAP_CTRL_EDGE_IRQ_EN
      step(1'b0, 1'b0, 64'h0, 4'd0, 2'd0, 1'b1, 3'b100, 3'b111);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'h0, 4'd0, 2'd0, 1'b1, 3'b000, 3'b111);
      step(1'b0, 1'b1, 64'h4000, 4'd0, 2'd0, 1'b1, 3'b000, 3'b111);
      expect_trap("edge_ext", IRQ_BIT | 64'd11, 64'h4000);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 64'h4004, 4'd0, 2'd0, 1'b1, 3'b000, 3'b111);
`endif

      for (int i = 0; i < 1500; i++) begin
         logic [3:0] exc;
         for (int b = 0; b < 4; b++) exc[b] = ($urandom_range(0, 9) == 0);
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 9) < 7),
              {32'd0, $urandom} & 64'hFFFF_FFFC,
              exc,
              2'($urandom_range(0, 3)),
              ($urandom_range(0, 9) < 7),
              {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3)},
              3'($urandom_range(0, 7)));
      end

      idle(4);
      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
